// File: rtl/fetcher_pkg.sv
// Shared fetch-stage types: core scheduler state codes and fetcher state codes.
package fetcher_pkg;

    typedef enum logic [2:0] {
        CoreIdle    = 3'b000,
        CoreFetch   = 3'b001,
        CoreDecode  = 3'b010,
        CoreRequest = 3'b011,
        CoreWait    = 3'b100,
        CoreExecute = 3'b101,
        CoreUpdate  = 3'b110,
        CoreDone    = 3'b111
    } core_state_t;

    typedef enum logic [2:0] {
        StIdle     = 3'b000,
        StFetching = 3'b001,
        StFetched  = 3'b010
    } fetcher_state_t;

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding consecutive prefetched instructions; flush beats push.
module fetch_fifo
    import fetcher_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    // Qualify requests: flush cancels both, push into a full FIFO only alongside a pop.
    always_comb begin
        do_pop  = pop && !flush && (count_q != '0);
        do_push = push && !flush && ((count_q != FULL_C) || do_pop);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/prefetch_fetcher.sv
// Instruction fetcher with a sequential prefetch buffer in front of program memory.
module prefetch_fetcher
    import fetcher_pkg::*;
#(
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
    parameter int unsigned PREFETCH_DEPTH        = 4,
    parameter bit          PREFETCH_EN           = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    localparam int unsigned AW = PROGRAM_MEM_ADDR_BITS;
    localparam int unsigned DW = PROGRAM_MEM_DATA_BITS;
    localparam int unsigned CW = $clog2(PREFETCH_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(PREFETCH_DEPTH);
    localparam logic [AW-1:0] PC_STEP = AW'(1);

    fetcher_state_t state_q;
    logic [DW-1:0]  instr_q;
    logic           valid_q;   // high exactly while a read is outstanding
    logic [AW-1:0]  addr_q;
    logic           disc_q;    // outstanding read belongs to a flushed stream
    logic [AW-1:0]  head_pc_q;
    logic [AW-1:0]  next_addr_q;

    logic [CW-1:0]  fifo_count;
    logic [DW-1:0]  fifo_head;
    logic           fetch_req, buf_hit, buf_miss;
    logic           resp, resp_keep, demand_done, fifo_push, issue;

    fetch_fifo #(
        .WIDTH (DW),
        .DEPTH (PREFETCH_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (mem_read_data),
        .pop       (buf_hit),
        .flush     (buf_miss),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Decode hit/miss, response routing and the single issue path.
    always_comb begin
        fetch_req   = (state_q == StIdle) && (core_state == CORE_FETCH);
        buf_hit     = fetch_req && (fifo_count != '0) && (head_pc_q == current_pc);
        buf_miss    = fetch_req && !buf_hit;
        resp        = valid_q && mem_read_ready;
        // A response racing a flush is as stale as one already marked for discard.
        resp_keep   = resp && !disc_q && !buf_miss;
        demand_done = resp_keep && (state_q == StFetching);
        fifo_push   = resp_keep && (state_q != StFetching) && PREFETCH_EN;
        // Issue is held off in the miss cycle so the refetch starts from the new PC.
        issue       = !valid_q && !buf_miss &&
                      ((state_q == StFetching) || (PREFETCH_EN && (fifo_count < DEPTH_C)));
    end

    // Fetch FSM plus request channel, discard flag and address counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            disc_q      <= 1'b0;
            head_pc_q   <= '0;
            next_addr_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (buf_hit) begin
                        instr_q   <= fifo_head;
                        head_pc_q <= head_pc_q + PC_STEP;
                        state_q   <= StFetched;
                    end else if (buf_miss) begin
                        head_pc_q <= current_pc;
                        state_q   <= StFetching;
                    end
                end
                StFetching: begin
                    if (demand_done) begin
                        instr_q   <= mem_read_data;
                        head_pc_q <= head_pc_q + PC_STEP;
                        state_q   <= StFetched;
                    end
                end
                StFetched: begin
                    if (core_state == CORE_DECODE) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            if (resp) begin
                valid_q <= 1'b0;
            end else if (issue) begin
                valid_q     <= 1'b1;
                addr_q      <= next_addr_q;
                next_addr_q <= next_addr_q + PC_STEP;
            end
            if (buf_miss) next_addr_q <= current_pc;

            if (buf_miss && valid_q && !mem_read_ready) begin
                disc_q <= 1'b1;
            end else if (resp) begin
                disc_q <= 1'b0;
            end
        end
    end

    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign fetcher_state    = state_q;
    assign instruction      = instr_q;

endmodule
